// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES block UART transmitter.
//   CLK_FREQ_DEFAULT / BAUD_RATE_DEFAULT : default clock and line rate
//   BLOCK_BYTES                          : bytes per 128-bit block
//   tx_state_t                           : byte serializer states
package aes_uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT  = 50_000_000;
  localparam int unsigned BAUD_RATE_DEFAULT = 115_200;
  localparam int unsigned BLOCK_BYTES       = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
//   clk, reset : clock, synchronous active-high reset
//   start      : load data and begin a frame (sampled in IDLE or on done)
//   data       : byte to send, LSB first
//   tx         : serial line, idle high (registered)
//   done       : high on the last cycle of the stop bit
//   idle       : serializer is in IDLE
module uart_tx_byte
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       idle
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud, baud_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shreg, shreg_next;
  logic              tx_q, tx_next;
  logic              bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      tx_q    <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    tx_next      = tx_q;
    done         = 1'b0;
    bit_end      = (baud == BAUD_LAST);
    baud_next    = bit_end ? '0 : baud + 1'b1;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (start) begin
          state_next = START;
          shreg_next = data;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            shreg_next   = {1'b0, shreg[7:1]};
            tx_next      = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done = 1'b1;
          // Chain straight into the next start bit when a byte is offered.
          if (start) begin
            state_next = START;
            shreg_next = data;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign idle = (state == IDLE);

endmodule

// File: rtl/aes_block_uart_tx.sv
// Queues 128-bit AES ciphertext blocks and sends them over a UART line,
// most significant byte first, with no gap between bytes of a block.
//   clk, reset  : clock, synchronous active-high reset
//   block_in    : 128-bit block from the AES CTR core
//   block_valid : block_in valid this cycle (no backpressure)
//   tx          : UART line, 8N1, idle high
//   busy        : FIFO non-empty or a frame on the line (registered)
//   full        : FIFO holds FIFO_DEPTH blocks (registered)
//   overflow    : sticky, a valid block was dropped
module aes_block_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] block_in,
  input  logic         block_valid,
  output logic         tx,
  output logic         busy,
  output logic         full,
  output logic         overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_BYTE = 4'(BLOCK_BYTES - 1);

  logic [127:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [3:0]       byte_idx, next_idx;
  logic [127:0]     head;
  logic [7:0]       tx_byte;
  logic             push, pop, have_next, start, done, line_idle;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The byte for the next frame is chosen combinationally so that a stop bit
  // chains into the following start bit, including across a pop, and a push
  // into an empty FIFO starts its frame on the push edge (write-through).
  always_comb begin
    pop      = done && (byte_idx == LAST_BYTE);
    push     = block_valid && ((count != CNT_FULL) || pop);
    next_idx = done ? byte_idx + 1'b1 : byte_idx;
    if (pop) begin
      have_next = (count > CNT_W'(1)) || push;
      head      = (count > CNT_W'(1)) ? mem[ptr_inc(rd_ptr)] : block_in;
    end else begin
      have_next = (count != '0) || push;
      head      = (count != '0) ? mem[rd_ptr] : block_in;
    end
    start   = (line_idle || done) && have_next;
    tx_byte = head[(BLOCK_BYTES - 1 - int'(next_idx)) * 8 +: 8];
    count_next = count;
    if (push && !pop) count_next = count + CNT_W'(1);
    if (pop && !push) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= block_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_next;
      byte_idx <= next_idx;
      busy     <= (count_next != '0);
      full     <= (count_next == CNT_FULL);
      if (block_valid && !push) overflow <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (tx_byte),
    .tx   (tx),
    .done (done),
    .idle (line_idle)
  );

endmodule

// File: tb/tb_aes_block_uart_tx.sv
module tb_aes_block_uart_tx;

  localparam int unsigned CPB   = 10;
  localparam int unsigned FRAME = 10 * CPB;
  localparam int unsigned BLK   = 16 * FRAME;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] block_in;
  logic         block_valid;
  logic         tx, busy, full, overflow;

  aes_block_uart_tx #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .block_in   (block_in),
    .block_valid(block_valid),
    .tx         (tx),
    .busy       (busy),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    int unsigned st;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      rx_q[$];
  int unsigned ends_q[$];
  int unsigned last_end = 0;
  logic        exp_ovf  = 1'b0;
  int unsigned epoch    = 0;
  int          checks   = 0;
  int          errors   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line receiver: decodes 8N1 frames from tx, timestamping each start bit
  // with the edge count at which the line went low.
  initial begin : receiver
    frame_t      f;
    int unsigned ep;
    logic [7:0]  sh;
    sh = '0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        f.st = cyc;
        ep   = epoch;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          sh = {tx, sh[7:1]};
        end
        repeat (CPB) @(negedge clk);
        f.b = sh;
        if (ep == epoch && tx === 1'b1) rx_q.push_back(f);
      end
    end
  end

  function automatic int occ_at(input int unsigned t);
    int n = 0;
    foreach (ends_q[i]) if (ends_q[i] > t) n++;
    return n;
  endfunction

  // Reference: a block accepted at edge t starts at t or when the previous
  // block finishes, occupies BLK cycles, and byte k starts k*FRAME later.
  task automatic model_push(input logic [127:0] blk, input int unsigned t);
    frame_t      f;
    int unsigned s;
    if (occ_at(t) < DEPTH) begin
      s        = (t > last_end) ? t : last_end;
      last_end = s + BLK;
      ends_q.push_back(last_end);
      for (int k = 0; k < 16; k++) begin
        f.b  = 8'(blk >> (8 * (15 - k)));
        f.st = s + k * FRAME;
        exp_q.push_back(f);
      end
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic push_block(input logic [127:0] blk);
    int unsigned t;
    block_in    = blk;
    block_valid = 1'b1;
    tick();
    block_valid = 1'b0;
    block_in    = 128'($urandom);
    t = cyc;
    model_push(blk, t);
    check("full", full, occ_at(t) == DEPTH);
    check("busy", busy, occ_at(t) > 0);
    check("overflow", overflow, exp_ovf);
  endtask

  task automatic do_reset(input int n, input logic with_valid);
    int unsigned r;
    frame_t      keep[$];
    epoch++;
    reset       = 1'b1;
    block_valid = with_valid;
    block_in    = {$urandom, $urandom, $urandom, $urandom};
    tick();
    r = cyc;
    repeat (n - 1) tick();
    reset       = 1'b0;
    block_valid = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].st + FRAME <= r) keep.push_back(exp_q[i]);
    exp_q    = keep;
    ends_q.delete();
    last_end = 0;
    exp_ovf  = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", n < bound, 1);
    idle_ticks(2 * FRAME);
  endtask

  task automatic compare_stream();
    frame_t e, r;
    while (exp_q.size() > 0) begin
      if (rx_q.size() == 0) begin
        check("rx_missing", 0, exp_q.size());
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      check("rx_byte", r.b, e.b);
      check("rx_start", r.st, e.st);
    end
    check("rx_extra", rx_q.size(), 0);
    rx_q.delete();
  endtask

  initial begin : timeout
    #3_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [127:0] a, b, c, d;
    int unsigned  t0, n;
    reset       = 1'b1;
    block_valid = 1'b0;
    block_in    = '0;

    // Reset with block_valid asserted: the block must be ignored.
    do_reset(3, 1'b1);
    idle_ticks(5);

    // Known block: start-bit latency, byte order, line occupancy.
    check("tx_idle_before_push", tx, 1);
    push_block(128'h00112233445566778899aabbccddeeff);
    check("tx_low_after_push", tx, 0);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("busy_length", n, BLK);
    idle_ticks(2 * FRAME);
    compare_stream();

    // Three consecutive pushes: third one dropped, overflow sticky.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    push_block(a);
    push_block(b);
    push_block(c);
    drain(5000);
    check("overflow_sticky", overflow, 1);
    compare_stream();
    do_reset(1, 1'b0);
    idle_ticks(3);

    // Full FIFO; push D on the exact edge A is popped.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom, $urandom, $urandom};
    push_block(a);
    t0 = cyc;
    push_block(b);
    while (cyc < t0 + BLK - 1 && busy === 1'b1) tick();
    push_block(d);
    check("no_overflow_on_pop_push", overflow, 0);
    drain(5000);
    compare_stream();

    // Reset during byte 7, then a fresh block starts at byte 0.
    a = {$urandom, $urandom, $urandom, $urandom};
    push_block(a);
    t0 = cyc;
    while (cyc < t0 + 7 * FRAME + FRAME / 2) tick();
    do_reset(1, 1'b0);
    idle_ticks(3 * FRAME);
    compare_stream();
    push_block({$urandom, $urandom, $urandom, $urandom});
    drain(3000);
    compare_stream();

    // Five-block run with random arrival gaps.
    for (int i = 0; i < 5; i++) begin
      idle_ticks($urandom_range(0, 1800));
      push_block({$urandom, $urandom, $urandom, $urandom});
    end
    drain(8000);
    check("overflow_run", overflow, exp_ovf);
    check("full_end", full, 0);
    compare_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
